if_id_queue: RTL and testbench

- Decoupling stage between the instruction fetch unit and the decode stage of the pipelined MIPS CPU.
- Accepts fetched instruction words (instruction plus PC+4) into a small in-order queue.
- Presents the oldest entry to decode with a valid/ready handshake.
- Drives the fetch stage's PC enable through in_ready, so decode stalls no longer have to freeze the PC register directly.
- Supports a flush that discards every queued instruction on a control-flow redirect.

---
 rtl/if_id_queue.sv | 146 ++++++++++++++
 tb/tb_if_id_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue
// -----------
// Decoupling queue between the instruction fetch unit and the decode stage.
// Fetched words {IR, PC+4} enter an in-order queue of DEPTH entries. The
// oldest entry is presented to decode through a valid/ready handshake.
// in_ready doubles as the fetch stage's PC enable, so a decode stall only
// back-pressures fetch once the queue is full. A flush discards everything
// queued, plus this cycle's input, on a control-flow redirect.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   IR_F       instruction word from fetch
//   PC4_F      PC+4 of IR_F
//   in_valid   fetch offers IR_F/PC4_F this cycle
//   in_ready   queue can accept a word (used by fetch as PC_en)
//   flush      discard all queued entries and this cycle's input
//   IR_D       oldest queued instruction, NOP_WORD when empty
//   PC4_D      PC+4 of IR_D, 0 when empty
//   PC_D       PC of IR_D (PC4_D - 4), 0 when empty
//   out_valid  IR_D/PC4_D hold a real instruction
//   out_ready  decode consumes the head this cycle (!stall)
//   count      current occupancy
//
// Optional feature, macro IF_ID_QUEUE_PERF_EN:
//   stall_cycles   edges where fetch was blocked by a full queue
//   bubble_cycles  edges where decode wanted a word but the queue was empty
//   Both are saturating 32-bit counters. Flush does not clear them.

module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter int          PTR_W    = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_F,
  input  logic [31:0]      PC4_F,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [31:0]      IR_D,
  output logic [31:0]      PC4_D,
  output logic [31:0]      PC_D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      bubble_cycles
`endif
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]    ir_mem_q  [DEPTH];
  logic [31:0]    pc4_mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push, pop;

  // Ready/valid depend only on occupancy, so in_ready never has a
  // combinational path from out_ready (no pass-through when full).
  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt_q;

  // An empty queue presents a NOP bubble so decode never sees stale data.
  assign IR_D  = out_valid ? ir_mem_q[rd_ptr_q]  : NOP_WORD;
  assign PC4_D = out_valid ? pc4_mem_q[rd_ptr_q] : 32'd0;
  assign PC_D  = out_valid ? (pc4_mem_q[rd_ptr_q] - 32'd4) : 32'd0;

  // Flush wins over push and pop; otherwise pointers advance independently
  // and the occupancy only moves when exactly one of push/pop happens.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage is not reset; out_valid masks it until written.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem_q[wr_ptr_q]  <= IR_F;
      pc4_mem_q[wr_ptr_q] <= PC4_F;
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] bubble_q, bubble_d;

  // Saturating event counters; deliberately untouched by flush.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (in_valid & ~in_ready & ~flush & (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
    if (out_ready & ~out_valid & (bubble_q != 32'hFFFF_FFFF))
      bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. A queue-based reference model tracks
// what the DUT must hold; a compare process checks every output against it
// on each falling edge, and directed scenarios add literal expectations.

module tb_if_id_queue;

  localparam int DEPTH_TB = 2;

  logic        clk;
  logic        reset;
  logic [31:0] IR_F, PC4_F;
  logic        in_valid, in_ready, flush;
  logic [31:0] IR_D, PC4_D, PC_D;
  logic        out_valid, out_ready;
  logic [1:0]  count;
`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles;
  logic [31:0] m_stall, m_bubble;
`endif

  int vectors;
  int errors;

  logic [63:0] mq[$];
  bit          model_live;

  if_id_queue #(.DEPTH(2), .PTR_W(1), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset), .IR_F(IR_F), .PC4_F(PC4_F),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .IR_D(IR_D), .PC4_D(PC4_D), .PC_D(PC_D),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
`ifdef IF_ID_QUEUE_PERF_EN
    , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain FIFO of {IR, PC4} updated from the rules.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      model_live = 1'b1;
`ifdef IF_ID_QUEUE_PERF_EN
      m_stall  = 0;
      m_bubble = 0;
`endif
    end else if (model_live) begin
      bit full, empty, do_push, do_pop;
      full    = (mq.size() == DEPTH_TB);
      empty   = (mq.size() == 0);
`ifdef IF_ID_QUEUE_PERF_EN
      if (in_valid && full && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (out_ready && empty && m_bubble != 32'hFFFF_FFFF) m_bubble++;
`endif
      do_push = in_valid && !full && !flush;
      do_pop  = !empty && out_ready && !flush;
      if (flush) mq.delete();
      else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back({IR_F, PC4_F});
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (model_live) begin
      logic [31:0] e_ir, e_pc4;
      bit          e_v;
      e_v   = (mq.size() != 0);
      e_ir  = e_v ? mq[0][63:32] : 32'h0;
      e_pc4 = e_v ? mq[0][31:0]  : 32'h0;
      checkOutput("count",     32'(count),     32'(mq.size()));
      checkOutput("out_valid", 32'(out_valid), 32'(e_v));
      checkOutput("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH_TB));
      checkOutput("IR_D",      IR_D,           e_ir);
      checkOutput("PC4_D",     PC4_D,          e_pc4);
      checkOutput("PC_D",      PC_D,           e_v ? e_pc4 - 32'd4 : 32'h0);
`ifdef IF_ID_QUEUE_PERF_EN
      checkOutput("stall_cycles",  stall_cycles,  m_stall);
      checkOutput("bubble_cycles", bubble_cycles, m_bubble);
`endif
    end
  end

  // Drive one cycle of inputs, then return #1 after the edge consuming them.
  task automatic applyStimulus(input logic iv, input logic [31:0] ir,
                               input logic [31:0] pc4, input logic ordy,
                               input logic fl);
    in_valid  = iv;
    IR_F      = ir;
    PC4_F     = pc4;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    model_live = 1'b0;
    reset = 1'b1;
    in_valid = 0; IR_F = 0; PC4_F = 0; out_ready = 0; flush = 0;

    // Reset then idle
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_IR_D",      IR_D,           32'h0);
    checkOutput("rst_count",     32'(count),     32'd0);

    // Single pass-through
    applyStimulus(1, 32'h3C010001, 32'h3004, 1, 0);
    checkOutput("pt_out_valid", 32'(out_valid), 32'd1);
    checkOutput("pt_IR_D",      IR_D,           32'h3C010001);
    checkOutput("pt_PC_D",      PC_D,           32'h3000);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pt_count", 32'(count), 32'd0);

    // Fill and stall
    applyStimulus(1, 32'hA, 32'h104, 0, 0);
    applyStimulus(1, 32'hB, 32'h108, 0, 0);
    checkOutput("fill_count",    32'(count),    32'd2);
    checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
    checkOutput("model_fill",    32'(mq.size()), 32'd2);
    applyStimulus(1, 32'hC, 32'h10C, 0, 0);
    checkOutput("full_count", 32'(count), 32'd2);
    checkOutput("full_IR_D",  IR_D,       32'hA);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pop1_IR_D",     IR_D,          32'hB);
    checkOutput("pop1_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pop2_out_valid", 32'(out_valid), 32'd0);

    // Streaming with pointer wrap
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 32'(i), 32'(32'h200 + 4 * i), 1, 0);
      checkOutput("stream_IR_D", IR_D, 32'(i));
      checkOutput("stream_cnt_le1", 32'(count <= 2'd1), 32'd1);
    end
    applyStimulus(0, 0, 0, 1, 0);

    // Flush priority
    applyStimulus(1, 32'h11, 32'h304, 0, 0);
    applyStimulus(1, 32'h22, 32'h308, 0, 0);
    applyStimulus(1, 32'hDEAD, 32'h30C, 1, 1);
    checkOutput("flush_count",     32'(count),     32'd0);
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("model_flush",     32'(mq.size()), 32'd0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("flush_no_dead", IR_D, 32'h0);

    // Async reset mid-stream
    applyStimulus(1, 32'h33, 32'h404, 0, 0);
    applyStimulus(1, 32'h44, 32'h408, 0, 0);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_count",     32'(count),     32'd0);
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
`ifdef IF_ID_QUEUE_PERF_EN
    checkOutput("arst_stall",  stall_cycles,  32'd0);
    checkOutput("arst_bubble", bubble_cycles, 32'd0);
`endif
    in_valid = 0; out_ready = 0; flush = 0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom,
                    $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
